// File: rtl/pipe_pkg.sv
// Shared constants and sequencer state type for the pipeline hazard controller.
package pipe_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mcState_t;

endpackage

// File: rtl/mc_seq.sv
// Multi-cycle op sequencer: holds EX for MC_LATENCY cycles (MC_LATENCY-1 busy, 1 done).
module mc_seq
    import pipe_pkg::*;
#(
    parameter int MC_LATENCY = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic mcStartE,
    input  logic pcsrcE,
    output logic busy,
    output logic done
);

    localparam logic [7:0] MC_LOAD = 8'(MC_LATENCY - 2);

    mcState_t   state;
    logic [7:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    // A branch resolving in the same cycle flushes the op instead of starting it.
                    if (mcStartE && !pcsrcE) begin
                        state <= BUSY;
                        count <= MC_LOAD;
                    end
                end
                BUSY: begin
                    if (count == 8'd0) state <= DONE;
                    else               count <= count - 8'd1;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs come straight from the state register; reset masks them in the reset cycle.
    assign busy = (state == BUSY) && !rst;
    assign done = (state == DONE) && !rst;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use stall, branch flush, multi-cycle sequencing.
// Define HAZARD_FWD_EN to enable EX-operand forwarding; otherwise all RAW hazards stall.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int MC_LATENCY     = 4,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_ADDR_WIDTH-1:0] rs1D,
    input  logic [REG_ADDR_WIDTH-1:0] rs2D,
    input  logic [REG_ADDR_WIDTH-1:0] rs1E,
    input  logic [REG_ADDR_WIDTH-1:0] rs2E,
    input  logic [REG_ADDR_WIDTH-1:0] rdE,
    input  logic [REG_ADDR_WIDTH-1:0] rdM,
    input  logic [REG_ADDR_WIDTH-1:0] rdW,
    input  logic                      regWriteE,
    input  logic                      regWriteM,
    input  logic                      regWriteW,
    input  logic [1:0]                resultSrcE,
    input  logic                      pcsrcE,
    input  logic                      mcStartE,
    output logic [1:0]                forwardAE,
    output logic [1:0]                forwardBE,
    output logic                      stallF,
    output logic                      stallD,
    output logic                      stallE,
    output logic                      flushD,
    output logic                      flushE,
    output logic                      flushM,
    output logic                      mcBusy,
    output logic                      mcDoneE,
    output logic [CNT_WIDTH-1:0]      stallCycles
);

    logic loadUse;
    logic depHaz;
    logic hazD;

    assign loadUse = (resultSrcE == RESULT_SRC_LOAD) && (rdE != '0) &&
                     ((rdE == rs1D) || (rdE == rs2D));

`ifdef HAZARD_FWD_EN
    logic unusedHaz;
    assign unusedHaz = regWriteE;
    assign depHaz    = 1'b0;

    always_comb begin
        forwardAE = FWD_RF;
        if (regWriteM && (rdM == rs1E) && (rs1E != '0))      forwardAE = FWD_M;
        else if (regWriteW && (rdW == rs1E) && (rs1E != '0)) forwardAE = FWD_W;

        forwardBE = FWD_RF;
        if (regWriteM && (rdM == rs2E) && (rs2E != '0))      forwardBE = FWD_M;
        else if (regWriteW && (rdW == rs2E) && (rs2E != '0)) forwardBE = FWD_W;
    end
`else
    logic unusedFwd;
    assign unusedFwd = ^{rs1E, rs2E, rdW, regWriteW};
    assign forwardAE = FWD_RF;
    assign forwardBE = FWD_RF;

    // Without forwarding, any in-flight producer of an ID source must drain first.
    assign depHaz = (regWriteE && (rdE != '0) && ((rdE == rs1D) || (rdE == rs2D))) ||
                    (regWriteM && (rdM != '0) && ((rdM == rs1D) || (rdM == rs2D)));
`endif

    assign hazD = loadUse || depHaz;

    mc_seq #(
        .MC_LATENCY(MC_LATENCY)
    ) u_mcSeq (
        .clk      (clk),
        .rst      (rst),
        .mcStartE (mcStartE),
        .pcsrcE   (pcsrcE),
        .busy     (mcBusy),
        .done     (mcDoneE)
    );

    // Priority: reset, then a busy multi-cycle op (EX cannot hold a branch), then flush, then stall.
    // NOTE: every output gets a default first so this block cannot infer a latch.
    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        flushM = 1'b0;
        if (rst) begin
            stallF = 1'b0;
        end else if (mcBusy) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            flushM = 1'b1;
        end else if (pcsrcE) begin
            flushD = 1'b1;
            flushE = 1'b1;
        end else if (hazD) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst)                                stallCycles <= '0;
        else if (stallF && (stallCycles != '1)) stallCycles <= stallCycles + 1'b1;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter REG_ADDR_WIDTH, default 5: register-address width.
REQ-002 Parameter MC_LATENCY, default 4, legal 2..255: EX-stage cycles a multi-cycle op occupies.
REQ-003 Parameter CNT_WIDTH, default 16: stall-cycle counter width.
REQ-004 Clock and reset ports: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-005 Register addresses, each in, REG_ADDR_WIDTH: rs1D, rs2D (ID sources); rs1E, rs2E (EX sources); rdE, rdM, rdW (destinations in EX/MEM/WB).
REQ-006 Write enables, each in, 1: regWriteE, regWriteM, regWriteW.
REQ-007 resultSrcE  in  2  EX result select; 2'b01 = load.
REQ-008 pcsrcE  in  1  taken branch or jump resolved in EX.
REQ-009 mcStartE  in  1  multi-cycle op (mul/div) present in EX.
REQ-010 forwardAE, forwardBE  out  2  EX operand select: 00 regfile, 01 resultW, 10 aluResultM.
REQ-011 Stall outputs, each out, 1: stallF, stallD, stallE.
REQ-012 Flush outputs, each out, 1: flushD, flushE, flushM (bubble into EX/MEM).
REQ-013 mcBusy  out  1  sequencer in BUSY; mcDoneE  out  1  multi-cycle result valid in EX this cycle.
REQ-014 stallCycles  out  CNT_WIDTH  saturating count of cycles with stallF=1.

Function
REQ-015 Forwarding SHALL be combinational: for operand A, 10 if regWriteM && rdM==rs1E && rs1E!=0; else 01 if regWriteW && rdW==rs1E && rs1E!=0; else 00; operand B identical on rs2E.
REQ-016 Load-use SHALL hold when resultSrcE==01 && rdE!=0 && (rdE==rs1D || rdE==rs2D); it drives stallF=stallD=flushE=1 for that cycle.
REQ-017 pcsrcE=1 SHALL drive flushD=flushE=1, force stallF=stallD=0 and suppress load-use stalls.
REQ-018 Sequencer states IDLE, BUSY, DONE; 8-bit down-counter.
REQ-019 IDLE->BUSY when mcStartE=1 && pcsrcE=0; counter loads MC_LATENCY-2.
REQ-020 In BUSY: stallF=stallD=stallE=flushM=1, mcBusy=1, load-use stalls subsumed, flushE=0; counter decrements each cycle; BUSY->DONE at counter==0.
REQ-021 DONE lasts one cycle: mcDoneE=1, no multi-cycle stalls; DONE->IDLE unconditionally, even if mcStartE=1.
REQ-022 A multi-cycle op thus holds EX for exactly MC_LATENCY cycles (MC_LATENCY-1 stalled, 1 DONE).
REQ-023 mcStartE=1 with pcsrcE=1 in IDLE: flush wins; no transition.
REQ-024 stallCycles increments by 1 on every cycle with stallF=1 and holds at 2^CNT_WIDTH-1.

Reset
REQ-025 rst=1 at a clock edge: state IDLE, counter 0, stallCycles 0.
REQ-026 While rst=1, all stall, flush, mcBusy and mcDoneE outputs are 0; reset mid-BUSY abandons the op with no DONE pulse.

Configuration
REQ-027 Macro HAZARD_FWD_EN defined: forwarding per REQ-015.
REQ-028 HAZARD_FWD_EN undefined: forwardAE=forwardBE=00; the REQ-016 stall and flush also fire on any rs1D/rs2D (nonzero) match with rdE (regWriteE) or rdM (regWriteM), regardless of resultSrcE.

Structure
REQ-029 Package pipe_pkg holds the forward-select constants (FWD_RF, FWD_W, FWD_M), the RESULT_SRC_LOAD constant and the sequencer state enum.
REQ-030 Sub-module mc_seq contains the sequencer FSM and down-counter; pipe_hazard_ctrl instantiates it once.

Verification
REQ-031 rdM=5, regWriteM=1, rs1E=5, rdW=5, regWriteW=1 -> forwardAE=10; rs1E=0 -> forwardAE=00.
REQ-032 resultSrcE=01, rdE=7, rs2D=7 -> stallF=stallD=flushE=1 for one cycle, stallCycles +1.
REQ-033 MC_LATENCY=4, mcStartE pulse -> mcBusy and stallE high for 3 cycles, then mcDoneE for 1 cycle, then IDLE.
REQ-034 pcsrcE=1 during a load-use match -> flushD=flushE=1, stallF=stallD=0.
REQ-035 rst asserted in second BUSY cycle -> next cycle IDLE, all outputs 0, no mcDoneE.
REQ-036 CNT_WIDTH=4, 20 consecutive stall cycles -> stallCycles saturates at 15.
